// File: rtl/pattern_generator.sv
`timescale 1ns/1ps
// pattern_generator
// Programmable 4-channel stimulus source. Holds DEPTH 4-bit patterns and
// plays steps 0..len out on a registered bus. Each step is held for hold+1
// cycles. Playback is one-shot, or a continuous loop when the build enables it.
//
// Build option:
//   PATGEN_LOOP_EN  defined   -> loop input honoured (continuous playback)
//                   undefined -> loop ignored, every run is one-shot
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   wr_en        write wr_data into slot wr_addr (any state)
//   wr_addr      slot index [AW-1:0]
//   wr_data      pattern value [3:0]
//   len          index of last step, captured at start
//   hold         extra cycles per step, captured at start
//   loop         continuous playback request, captured at start
//   start        begin playback (ignored while running)
//   stop         abort playback (wins over start)
//   out_data     current pattern (0 when idle)
//   step_strobe  pulse in the first cycle of every step
//   busy         high while playing
//   done         pulse when a one-shot sequence completes
module pattern_generator #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned HOLD_W = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [3:0]        wr_data,
    input  logic [AW-1:0]     len,
    input  logic [HOLD_W-1:0] hold,
    input  logic              loop,
    input  logic              start,
    input  logic              stop,
    output logic [3:0]        out_data,
    output logic              step_strobe,
    output logic              busy,
    output logic              done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        state, state_d;
    logic [AW-1:0]     idx, idx_d;
    logic [AW-1:0]     len_r, len_d;
    logic [HOLD_W-1:0] cnt, cnt_d;
    logic [HOLD_W-1:0] hold_r, hold_d;
    logic              loop_r, loop_d;
    logic              step_strobe_d;
    logic              busy_d;
    logic              done_d;
    logic [3:0]        out_data_d;
    logic [3:0]        rd_data_c;

    logic [3:0]        mem [DEPTH];

`ifndef PATGEN_LOOP_EN
    // Loop request has no effect in this build.
    logic unused_loop;
    assign unused_loop = loop;
`endif

    // Pattern memory: cleared on reset, writable in any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= 4'h0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            len_r       <= '0;
            hold_r      <= '0;
            loop_r      <= 1'b0;
            out_data    <= 4'h0;
            step_strobe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            cnt         <= cnt_d;
            len_r       <= len_d;
            hold_r      <= hold_d;
            loop_r      <= loop_d;
            out_data    <= out_data_d;
            step_strobe <= step_strobe_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state;
        idx_d         = idx;
        cnt_d         = cnt;
        len_d         = len_r;
        hold_d        = hold_r;
        loop_d        = loop_r;
        step_strobe_d = 1'b0;
        done_d        = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_d       = RUN;
                    idx_d         = '0;
                    cnt_d         = hold;
                    len_d         = len;
                    hold_d        = hold;
`ifdef PATGEN_LOOP_EN
                    loop_d        = loop;
`else
                    loop_d        = 1'b0;
`endif
                    step_strobe_d = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt != '0) begin
                    cnt_d = HOLD_W'(cnt - 1'b1);
                end else if (idx != len_r) begin
                    idx_d         = AW'(idx + 1'b1);
                    cnt_d         = hold_r;
                    step_strobe_d = 1'b1;
`ifdef PATGEN_LOOP_EN
                end else if (loop_r) begin
                    idx_d         = '0;
                    cnt_d         = hold_r;
                    step_strobe_d = 1'b1;
`endif
                end else begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == RUN);

        // Forward a same-cycle write so the presented slot updates next cycle.
        rd_data_c  = (wr_en && (wr_addr == idx_d)) ? wr_data : mem[idx_d];
        out_data_d = busy_d ? rd_data_c : 4'h0;
    end

endmodule

// File: tb/tb_pattern_generator.sv
`timescale 1ns/1ps
module tb_pattern_generator;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned AW     = 3;
    localparam int unsigned HOLD_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [3:0]        wr_data;
    logic [AW-1:0]     len;
    logic [HOLD_W-1:0] hold;
    logic              loop;
    logic              start;
    logic              stop;
    logic [3:0]        out_data;
    logic              step_strobe;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    // Behavioural picture of the pattern slots.
    logic [3:0] mem_m [DEPTH];

    always #5 clk = ~clk;

    pattern_generator #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .hold(hold), .loop(loop), .start(start), .stop(stop),
        .out_data(out_data), .step_strobe(step_strobe), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input bit exp_done);
        chk({tag, "_data"}, 32'(out_data), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_strobe"}, 32'(step_strobe), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
    endtask

    task automatic end_idle;
        tick;
        chk_idle("idle_after", 1'b0);
    endtask

    task automatic write_slot(input int a, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick;
        wr_en   = 1'b0;
        mem_m[a] = d;
    endtask

    // Plays one run and checks every cycle against a step/hold walk of the
    // sequence. Optional mid-run write at wr_cyc, optional stop at stop_cyc,
    // loop runs are stopped after max_cyc cycles. A done cycle is left pending
    // so the caller can restart in it.
    task automatic run_seq(input int l, input int h, input bit lp,
                           input int wr_cyc, input int wa, input logic [3:0] wd,
                           input int stop_cyc, input int max_cyc);
        int s;
        int k;
        int cyc;
        bit ended;
        bit lp_eff;
        s = 0; k = 0; cyc = 1; ended = 1'b0;
`ifdef PATGEN_LOOP_EN
        lp_eff = lp;
`else
        lp_eff = 1'b0;
`endif
        len = AW'(l); hold = HOLD_W'(h); loop = lp; start = 1'b1;
        tick;
        start = 1'b0;
        // Changed inputs must not affect the run in progress.
        len = AW'(~l); hold = HOLD_W'(h + 7); loop = ~lp;
        while (!ended && cyc <= max_cyc) begin
            chk("run_data", 32'(out_data), 32'(mem_m[s]));
            chk("run_strobe", 32'(step_strobe), 32'(k == 0));
            chk("run_busy", 32'(busy), 32'h1);
            chk("run_done", 32'(done), 32'h0);
            if (cyc == stop_cyc) begin
                stop = 1'b1;
                tick;
                stop = 1'b0;
                chk_idle("stop", 1'b0);
                return;
            end
            if (cyc == wr_cyc) begin
                wr_en = 1'b1; wr_addr = AW'(wa); wr_data = wd;
                mem_m[wa] = wd;
            end
            start = (cyc == 3);
            k++;
            if (k > h) begin
                k = 0;
                s++;
                if (s > l) begin
                    if (lp_eff) s = 0;
                    else ended = 1'b1;
                end
            end
            tick;
            wr_en = 1'b0;
            start = 1'b0;
            cyc++;
        end
        if (ended) begin
            chk_idle("done_pulse", 1'b1);
        end else begin
            stop = 1'b1;
            tick;
            stop = 1'b0;
            chk_idle("loop_stop", 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        len = '0; hold = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = 4'h0;
        tick; tick;
        chk_idle("reset", 1'b0);
        rst = 1'b0;
        tick;
        chk_idle("post_reset", 1'b0);

        // One-shot A,A,5,5,F,F then done.
        write_slot(0, 4'hA); write_slot(1, 4'h5); write_slot(2, 4'hF);
        run_seq(2, 1, 1'b0, -1, 0, 4'h0, -1, 5000);
        end_idle;

        // Loop A,5,A,5... (one-shot A,5 + done when loop is not built).
        run_seq(1, 0, 1'b1, -1, 0, 4'h0, -1, 10);
        end_idle;

        // Stop on 2nd cycle of step 1.
        run_seq(2, 3, 1'b0, -1, 0, 4'h0, 6, 5000);
        end_idle;

        // start with stop from IDLE stays idle.
        start = 1'b1; stop = 1'b1;
        tick;
        start = 1'b0; stop = 1'b0;
        chk_idle("start_stop", 1'b0);
        end_idle;

        // Mid-run write to slot 2 before it plays; hold input changes mid-run.
        run_seq(2, 1, 1'b0, 2, 2, 4'h3, -1, 5000);
        end_idle;

        // Write to the slot being presented, then restart in the done cycle.
        run_seq(1, 4, 1'b0, 2, 0, 4'hC, -1, 5000);
        run_seq(0, 0, 1'b0, -1, 0, 4'h0, -1, 5000);
        end_idle;

        // Single step looping at hold 0: strobe every cycle.
        run_seq(0, 0, 1'b1, -1, 0, 4'h0, -1, 6);
        end_idle;

        // Randomized runs.
        for (int it = 0; it < 6; it++) begin
            int l;
            int h;
            for (int a = 0; a < int'(DEPTH); a++) write_slot(a, 4'($urandom));
            l = int'($urandom_range(0, 7));
            h = int'($urandom_range(0, 4));
            run_seq(l, h, it[0], int'($urandom_range(1, 12)), int'($urandom_range(0, 7)),
                    4'($urandom), (it == 4) ? 3 : -1, int'($urandom_range(5, 25)));
            end_idle;
        end

        // Reset during step 1: outputs clear at once, memory cleared.
        write_slot(0, 4'h9);
        len = 2; hold = 3; loop = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        rst = 1'b1;
        #1;
        chk_idle("async_reset", 1'b0);
        tick;
        rst = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = 4'h0;
        tick;
        chk_idle("after_reset", 1'b0);
        run_seq(1, 0, 1'b0, -1, 0, 4'h0, -1, 5000);
        end_idle;

        // Largest sequence: 8 steps x 256 cycles.
        for (int a = 0; a < int'(DEPTH); a++) write_slot(a, 4'($urandom));
        run_seq(7, 255, 1'b0, -1, 0, 4'h0, -1, 5000);
        end_idle;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
